id_ex_hazard_stage: RTL and testbench

//  ID/EX pipeline register plus the hazard controller that feeds the EX-stage forwarding unit.

---
 rtl/id_ex_hazard_stage.sv | 103 ++++++++++
 tb/tb_id_ex_hazard_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// multi-cycle mult/div hold; drives the IF-side stall and EX hold signals.
module id_ex_hazard_stage #(
  parameter int N      = 32,
  parameter int W      = 32,
  parameter int MD_LAT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [$clog2(N)-1:0] i_rs_id,
  input  logic [$clog2(N)-1:0] i_rt_id,
  input  logic                 i_uses_rt_id,
  input  logic [$clog2(N)-1:0] i_write_reg_id,
  input  logic [W-1:0]         i_rd1_id,
  input  logic [W-1:0]         i_rd2_id,
  input  logic [W-1:0]         i_imm_id,
  input  logic [7:0]           i_ctrl_id,
  input  logic                 i_md_start_id,
  input  logic                 i_flush,
  output logic                 o_stall_if,
  output logic                 o_ex_hold,
  output logic [$clog2(N)-1:0] o_rs_ex,
  output logic [$clog2(N)-1:0] o_rt_ex,
  output logic [$clog2(N)-1:0] o_write_reg_ex,
  output logic [W-1:0]         o_rd1_ex,
  output logic [W-1:0]         o_rd2_ex,
  output logic [W-1:0]         o_imm_ex,
  output logic [7:0]           o_ctrl_ex,
  output logic                 o_md_busy
);

  localparam int IW       = $clog2(N);
  localparam int CW       = $clog2(MD_LAT);
  localparam int MEM_READ = 6;

  logic [IW-1:0] r_rs;
  logic [IW-1:0] r_rt;
  logic [IW-1:0] r_write_reg;
  logic [W-1:0]  r_rd1;
  logic [W-1:0]  r_rd2;
  logic [W-1:0]  r_imm;
  logic [7:0]    r_ctrl;
  logic [CW-1:0] r_cnt;

  logic w_md_busy;
  logic w_rs_match;
  logic w_rt_match;
  logic w_load_use;

  // A bubble carries write_reg 0, so it can never look like a pending load.
  assign w_md_busy  = (r_cnt != '0);
  assign w_rs_match = (r_write_reg == i_rs_id);
  assign w_rt_match = i_uses_rt_id & (r_write_reg == i_rt_id);
  assign w_load_use = r_ctrl[MEM_READ] & (r_write_reg != '0) & (w_rs_match | w_rt_match);

  assign o_md_busy  = w_md_busy;
  assign o_ex_hold  = w_md_busy;
  assign o_stall_if = w_md_busy | (w_load_use & ~i_flush);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_ctrl      <= '0;
      r_cnt       <= '0;
    end else if (w_md_busy) begin
      // Mult/div still occupies EX: fields stay put, flush cannot come from EX.
      r_cnt <= r_cnt - CW'(1);
    end else if (i_flush || w_load_use) begin
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_ctrl      <= '0;
    end else begin
      r_rs        <= i_rs_id;
      r_rt        <= i_rt_id;
      r_write_reg <= i_write_reg_id;
      r_rd1       <= i_rd1_id;
      r_rd2       <= i_rd2_id;
      r_imm       <= i_imm_id;
      r_ctrl      <= i_ctrl_id;
      if (i_md_start_id) begin
        r_cnt <= CW'(MD_LAT - 1);
      end
    end
  end

  assign o_rs_ex        = r_rs;
  assign o_rt_ex        = r_rt;
  assign o_write_reg_ex = r_write_reg;
  assign o_rd1_ex       = r_rd1;
  assign o_rd2_ex       = r_rd2;
  assign o_imm_ex       = r_imm;
  assign o_ctrl_ex      = r_ctrl;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed testbench for id_ex_hazard_stage: reset, load-use, false-stall,
// flush priority, mult/div hold, back-to-back mult/div and reset mid-hold.
module tb_id_ex_hazard_stage;

  localparam int N      = 32;
  localparam int W      = 32;
  localparam int MD_LAT = 4;
  localparam int IW     = $clog2(N);

  localparam logic [7:0] CTRL_LW   = 8'hD8;
  localparam logic [7:0] CTRL_ADD  = 8'h82;
  localparam logic [7:0] CTRL_ADDI = 8'h88;
  localparam logic [7:0] CTRL_MD   = 8'h80;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] rsId, rtId, writeRegId;
  logic          usesRtId, mdStartId, flush;
  logic [W-1:0]  rd1Id, rd2Id, immId;
  logic [7:0]    ctrlId;
  logic          stallIf, exHold, mdBusy;
  logic [IW-1:0] rsEx, rtEx, writeRegEx;
  logic [W-1:0]  rd1Ex, rd2Ex, immEx;
  logic [7:0]    ctrlEx;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.N(N), .W(W), .MD_LAT(MD_LAT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rs_id        (rsId),
    .i_rt_id        (rtId),
    .i_uses_rt_id   (usesRtId),
    .i_write_reg_id (writeRegId),
    .i_rd1_id       (rd1Id),
    .i_rd2_id       (rd2Id),
    .i_imm_id       (immId),
    .i_ctrl_id      (ctrlId),
    .i_md_start_id  (mdStartId),
    .i_flush        (flush),
    .o_stall_if     (stallIf),
    .o_ex_hold      (exHold),
    .o_rs_ex        (rsEx),
    .o_rt_ex        (rtEx),
    .o_write_reg_ex (writeRegEx),
    .o_rd1_ex       (rd1Ex),
    .o_rd2_ex       (rd2Ex),
    .o_imm_ex       (immEx),
    .o_ctrl_ex      (ctrlEx),
    .o_md_busy      (mdBusy)
  );

  // Present one ID-stage instruction; the settle delay lets combinational outputs update.
  task automatic applyStimulus(input logic [IW-1:0] rs, input logic [IW-1:0] rt,
                               input logic usesRt, input logic [IW-1:0] wr,
                               input logic [7:0] ctrl, input logic md, input logic fl,
                               input logic [W-1:0] rd1);
    rsId       = rs;
    rtId       = rt;
    usesRtId   = usesRt;
    writeRegId = wr;
    ctrlId     = ctrl;
    mdStartId  = md;
    flush      = fl;
    rd1Id      = rd1;
    rd2Id      = rd1 ^ 32'hFFFF_0000;
    immId      = rd1 + 32'd1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with random ID-stage values
    rst = 1'b1;
    applyStimulus(IW'($urandom), IW'($urandom), 1'b1, IW'($urandom), 8'($urandom),
                  1'b1, 1'b0, $urandom);
    tick();
    applyStimulus(IW'($urandom), IW'($urandom), 1'b1, IW'($urandom), 8'($urandom),
                  1'b1, 1'b0, $urandom);
    tick();
    checkOutput("rst_ctrl_ex", 32'(ctrlEx), 32'h0);
    checkOutput("rst_write_reg_ex", 32'(writeRegEx), 32'h0);
    checkOutput("rst_stall_if", 32'(stallIf), 32'h0);
    checkOutput("rst_md_busy", 32'(mdBusy), 32'h0);
    rst = 1'b0;

    // lw $5 enters EX
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd5, CTRL_LW, 1'b0, 1'b0, 32'h100);
    tick();
    checkOutput("lw_ctrl_ex", 32'(ctrlEx), 32'(CTRL_LW));
    checkOutput("lw_write_reg_ex", 32'(writeRegEx), 32'd5);

    // add rs=5 rt=7 depends on the load
    applyStimulus(5'd5, 5'd7, 1'b1, 5'd8, CTRL_ADD, 1'b0, 1'b0, 32'hA5A5_0001);
    checkOutput("lu_stall_if", 32'(stallIf), 32'h1);
    checkOutput("lu_ex_hold", 32'(exHold), 32'h0);
    tick();
    checkOutput("lu_bubble_ctrl", 32'(ctrlEx), 32'h0);
    checkOutput("lu_bubble_rs", 32'(rsEx), 32'h0);
    checkOutput("lu_stall_clears", 32'(stallIf), 32'h0);
    tick();
    checkOutput("lu_rs_ex", 32'(rsEx), 32'd5);
    checkOutput("lu_rt_ex", 32'(rtEx), 32'd7);
    checkOutput("lu_ctrl_ex", 32'(ctrlEx), 32'(CTRL_ADD));
    checkOutput("lu_rd1_ex", rd1Ex, 32'hA5A5_0001);
    checkOutput("lu_rd2_ex", rd2Ex, 32'h5A5A_0001);
    checkOutput("lu_imm_ex", immEx, 32'hA5A5_0002);

    // Load to $0 never stalls
    applyStimulus(5'd3, 5'd4, 1'b0, 5'd0, CTRL_LW, 1'b0, 1'b0, 32'h200);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd11, CTRL_ADD, 1'b0, 1'b0, 32'h300);
    checkOutput("r0_no_stall", 32'(stallIf), 32'h0);
    tick();
    checkOutput("r0_ctrl_ex", 32'(ctrlEx), 32'(CTRL_ADD));
    checkOutput("r0_write_reg_ex", 32'(writeRegEx), 32'd11);

    // rt match ignored when rt is not read
    applyStimulus(5'd3, 5'd4, 1'b0, 5'd9, CTRL_LW, 1'b0, 1'b0, 32'h400);
    tick();
    applyStimulus(5'd3, 5'd9, 1'b0, 5'd10, CTRL_ADDI, 1'b0, 1'b0, 32'h500);
    checkOutput("rt_no_stall", 32'(stallIf), 32'h0);
    tick();
    checkOutput("rt_rt_ex", 32'(rtEx), 32'd9);
    checkOutput("rt_ctrl_ex", 32'(ctrlEx), 32'(CTRL_ADDI));
    checkOutput("rt_write_reg_ex", 32'(writeRegEx), 32'd10);

    // Flush beats load-use
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd6, CTRL_LW, 1'b0, 1'b0, 32'h600);
    tick();
    applyStimulus(5'd6, 5'd2, 1'b1, 5'd12, CTRL_ADD, 1'b0, 1'b1, 32'h700);
    checkOutput("fl_stall_if", 32'(stallIf), 32'h0);
    tick();
    checkOutput("fl_ctrl_ex", 32'(ctrlEx), 32'h0);
    checkOutput("fl_write_reg_ex", 32'(writeRegEx), 32'h0);

    // Mult/div capture and hold for MD_LAT-1 cycles
    applyStimulus(5'd11, 5'd12, 1'b1, 5'd13, CTRL_MD, 1'b1, 1'b0, 32'h800);
    tick();
    applyStimulus(5'd14, 5'd15, 1'b1, 5'd16, CTRL_ADD, 1'b0, 1'b1, 32'h900);
    for (int i = 0; i < MD_LAT - 1; i++) begin
      checkOutput($sformatf("md_busy_%0d", i), 32'(mdBusy), 32'h1);
      checkOutput($sformatf("md_stall_%0d", i), 32'(stallIf), 32'h1);
      checkOutput($sformatf("md_hold_%0d", i), 32'(exHold), 32'h1);
      checkOutput($sformatf("md_rs_ex_%0d", i), 32'(rsEx), 32'd11);
      checkOutput($sformatf("md_ctrl_ex_%0d", i), 32'(ctrlEx), 32'(CTRL_MD));
      checkOutput($sformatf("md_rd1_ex_%0d", i), rd1Ex, 32'h800);
      tick();
      flush = 1'b0;
      #1;
    end
    checkOutput("md_release_busy", 32'(mdBusy), 32'h0);
    checkOutput("md_release_stall", 32'(stallIf), 32'h0);
    checkOutput("md_release_rs_ex", 32'(rsEx), 32'd11);

    // Second md op captured on the release cycle restarts the counter
    applyStimulus(5'd17, 5'd18, 1'b1, 5'd19, CTRL_MD, 1'b1, 1'b0, 32'hA00);
    tick();
    checkOutput("md2_rs_ex", 32'(rsEx), 32'd17);
    checkOutput("md2_busy", 32'(mdBusy), 32'h1);
    applyStimulus(5'd20, 5'd21, 1'b1, 5'd22, CTRL_ADD, 1'b0, 1'b0, 32'hB00);
    tick();
    checkOutput("md2_busy_cnt2", 32'(mdBusy), 32'h1);

    // Reset while the counter is at 2
    rst = 1'b1;
    #1;
    tick();
    checkOutput("rsthold_busy", 32'(mdBusy), 32'h0);
    checkOutput("rsthold_stall", 32'(stallIf), 32'h0);
    checkOutput("rsthold_ctrl_ex", 32'(ctrlEx), 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
